// File: rtl/shift_arbiter_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_arbiter_ctrl_if
// Description : Requester/arbiter bundle for shift_arbiter_ctrl. Two request
//               ports (operand, count, op, combinational grant) plus the
//               shared result return (busy, done pulse, id, result).
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_arbiter_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  // Port 0: ALU shift path
  logic                  req0;
  logic [DATA_WIDTH-1:0] data0;
  logic [ADDR_WIDTH-1:0] count0;
  logic [1:0]            op0;
  logic                  gnt0;
  // Port 1: load/store byte-align path
  logic                  req1;
  logic [DATA_WIDTH-1:0] data1;
  logic [ADDR_WIDTH-1:0] count1;
  logic [1:0]            op1;
  logic                  gnt1;
  // Shared result return
  logic                  busy;
  logic                  done;
  logic                  done_id;
  logic [DATA_WIDTH-1:0] result;

  // Requester side
  modport master (
    output req0, data0, count0, op0,
    output req1, data1, count1, op1,
    input  gnt0, gnt1, busy, done, done_id, result
  );

  // Arbiter side
  modport slave (
    input  req0, data0, count0, op0,
    input  req1, data1, count1, op1,
    output gnt0, gnt1, busy, done, done_id, result
  );
endinterface
`default_nettype wire

// File: rtl/shift_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_arbiter_ctrl
// Description : Two-port round-robin arbiter and sequencer for one shared
//               barrel shifter (sll/srl/sra/rotr). Captures the winner's
//               operands at grant, shifts from registers, registers the
//               result and returns it with a one-cycle done pulse + id.
//               Optional build macro: SHIFT_ARB_ZERO_SKIP_EN (count==0 ops
//               bypass the SHIFT state and complete one cycle earlier).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_arbiter_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input wire                  clk,
  input wire                  rst,
  shift_arbiter_ctrl_if.slave bus
);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_SHIFT = 2'd1;
  localparam logic [1:0] C_DONE  = 2'd2;

  logic [1:0]            state_q,  state_d;
  logic                  last_q,   last_d;
  logic                  id_q,     id_d;
  logic [DATA_WIDTH-1:0] data_q,   data_d;
  logic [ADDR_WIDTH-1:0] count_q,  count_d;
  logic [1:0]            op_q,     op_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  logic                  w_any_req;
  logic                  w_win_id;
  logic                  w_accept;
  logic                  w_zero_skip;
  logic [DATA_WIDTH-1:0] w_win_data;
  logic [ADDR_WIDTH-1:0] w_win_count;
  logic [1:0]            w_win_op;
  logic [DATA_WIDTH-1:0] w_shift_out;

  // Arbitration: a lone requester wins; on a tie the port that did not win last time wins
  always_comb begin
    w_any_req = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      w_win_id = ~last_q;
    end else begin
      w_win_id = bus.req1;
    end
    w_win_data  = w_win_id ? bus.data1  : bus.data0;
    w_win_count = w_win_id ? bus.count1 : bus.count0;
    w_win_op    = w_win_id ? bus.op1    : bus.op0;
    // Grants only leave the block from IDLE and never while reset is held
    w_accept    = (state_q == C_IDLE) && w_any_req && !rst;
  end

`ifdef SHIFT_ARB_ZERO_SKIP_EN
  // A zero shift is the identity, so such ops skip straight to DONE
  assign w_zero_skip = (w_win_count == '0);
`else
  assign w_zero_skip = 1'b0;
`endif

  // Barrel shifter working purely from the latched operands
  always_comb begin
    case (op_q)
      2'd0:    w_shift_out = data_q << count_q;
      2'd1:    w_shift_out = data_q >> count_q;
      2'd2:    w_shift_out = $unsigned($signed(data_q) >>> count_q);
      default: w_shift_out = DATA_WIDTH'({data_q, data_q} >> count_q);
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= C_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:  if (w_accept) state_d = w_zero_skip ? C_DONE : C_SHIFT;
      C_SHIFT: state_d = C_DONE;
      C_DONE:  state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  // FSM outputs: Mealy grants in IDLE, Moore busy/done from the state
  always_comb begin
    bus.gnt0    = w_accept && !w_win_id;
    bus.gnt1    = w_accept &&  w_win_id;
    bus.busy    = (state_q != C_IDLE);
    bus.done    = (state_q == C_DONE);
    bus.done_id = (state_q == C_DONE) && id_q;
    bus.result  = result_q;
  end

  // Datapath next values: capture at grant, register shift result, rotate priority at done
  always_comb begin
    data_d   = data_q;
    count_d  = count_q;
    op_d     = op_q;
    id_d     = id_q;
    last_d   = last_q;
    result_d = result_q;
    case (state_q)
      C_IDLE: begin
        if (w_accept) begin
          data_d  = w_win_data;
          count_d = w_win_count;
          op_d    = w_win_op;
          id_d    = w_win_id;
          if (w_zero_skip) begin
            result_d = w_win_data;
          end
        end
      end
      C_SHIFT: result_d = w_shift_out;
      C_DONE:  last_d   = id_q;
      default: ;
    endcase
  end

  // Datapath registers; last resets to 1 so port 0 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      count_q  <= '0;
      op_q     <= '0;
      id_q     <= 1'b0;
      last_q   <= 1'b1;
      result_q <= '0;
    end else begin
      data_q   <= data_d;
      count_q  <= count_d;
      op_q     <= op_d;
      id_q     <= id_d;
      last_q   <= last_d;
      result_q <= result_d;
    end
  end

endmodule
`default_nettype wire
